// File: rtl/spi_pkg.sv
// Shared SPI constants and status-word layout,
// common to the SPI master and slave.
package spi_pkg;

  localparam int RXV = 15;
  localparam int OVR = 14;
  localparam int TXF = 13;
  localparam int ACT = 12;

  localparam logic [7:0] DUMMY_DEF = 8'hFF;
  localparam logic [1:0] SPI_MODE  = 2'd0;

  typedef enum logic {
    ST_IDLE,
    ST_ACTIVE
  } spi_state_e;

  function automatic logic [15:0] pack_status(
    input logic       rxv,
    input logic       ovr,
    input logic       txf,
    input logic       act,
    input logic [7:0] data
  );
    logic [15:0] w;
    w      = '0;
    w[RXV] = rxv;
    w[OVR] = ovr;
    w[TXF] = txf;
    w[ACT] = act;
    w[7:0] = data;
    return w;
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Multi-stage pin synchroniser with a history flop
// for rising/falling edge detection.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic              hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    hist_d = sync_q[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      hist_q <= RST_VAL;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign q    = sync_q[STAGES-1];
  assign rise = q & ~hist_q;
  assign fall = ~q & hist_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 responder, MSB first, 8-bit frames,
// with a one-deep transmit buffer and status word.
module spi_slave
  import spi_pkg::*;
#(
  parameter logic [7:0] DUMMY       = DUMMY_DEF,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        rd,
  input  logic [15:0] in,
  output logic [15:0] out,
  input  logic        CSX,
  input  logic        SCK,
  input  logic        SDI,
  output logic        SDO
);

  logic sck_s, sck_rise, sck_fall;
  logic csx_s, csx_rise, csx_fall;
  logic sdi_s, sdi_rise, sdi_fall;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SCK),
    .q    (sck_s),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_csx (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (CSX),
    .q    (csx_s),
    .rise (csx_rise),
    .fall (csx_fall)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sdi (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (SDI),
    .q    (sdi_s),
    .rise (sdi_rise),
    .fall (sdi_fall)
  );

  logic unused_sig;
  assign unused_sig = ^{in[15:8], sdi_rise, sdi_fall,
                        sck_s, csx_s};

  spi_state_e state_q, state_d;
  logic       active;

  logic [7:0] tx_buf_q, tx_buf_d;
  logic       tx_full_q, tx_full_d;
  logic [7:0] tx_shift_q, tx_shift_d;
  logic [7:0] rx_shift_q, rx_shift_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       overrun_q, overrun_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic       byte_done_q, byte_done_d;

  logic reload, shift, complete;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (csx_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (csx_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    active = (state_q == ST_ACTIVE);
  end

  always_comb begin
    tx_buf_d    = tx_buf_q;
    tx_full_d   = tx_full_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    bitcnt_d    = bitcnt_q;
    byte_done_d = byte_done_q;
    reload      = 1'b0;
    shift       = 1'b0;
    complete    = 1'b0;

    if (csx_fall) begin
      bitcnt_d    = 3'd0;
      byte_done_d = 1'b0;
      reload      = 1'b1;
    end else if (csx_rise) begin
      bitcnt_d    = 3'd0;
      byte_done_d = 1'b0;
      rx_shift_d  = 8'd0;
    end else if (active) begin
      if (sck_rise) begin
        rx_shift_d = {rx_shift_q[6:0], sdi_s};
        bitcnt_d   = bitcnt_q + 3'd1;
        if (bitcnt_q == 3'd7) begin
          complete    = 1'b1;
          byte_done_d = 1'b1;
        end
      end else if (sck_fall) begin
        if (byte_done_q) begin
          reload      = 1'b1;
          byte_done_d = 1'b0;
        end else begin
          shift = 1'b1;
        end
      end
    end

    // reload uses the old buffer; a same-cycle load re-queues
    if (reload) begin
      tx_shift_d = tx_full_q ? tx_buf_q : DUMMY;
      tx_full_d  = 1'b0;
    end else if (shift) begin
      tx_shift_d = {tx_shift_q[6:0], 1'b0};
    end

    if (load) begin
      tx_buf_d  = in[7:0];
      tx_full_d = 1'b1;
    end

    if (complete) rx_data_d = rx_shift_d;

    rx_valid_d = complete | (rx_valid_q & ~rd);
    overrun_d  = ~rd & (overrun_q | (complete & rx_valid_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_buf_q    <= 8'd0;
      tx_full_q   <= 1'b0;
      tx_shift_q  <= DUMMY;
      rx_shift_q  <= 8'd0;
      rx_data_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      overrun_q   <= 1'b0;
      bitcnt_q    <= 3'd0;
      byte_done_q <= 1'b0;
    end else begin
      tx_buf_q    <= tx_buf_d;
      tx_full_q   <= tx_full_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      overrun_q   <= overrun_d;
      bitcnt_q    <= bitcnt_d;
      byte_done_q <= byte_done_d;
    end
  end

  assign out = pack_status(rx_valid_q, overrun_q,
                           tx_full_q, active, rx_data_q);
  assign SDO = active ? tx_shift_q[7] : 1'b1;

endmodule
